// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for dmem_access_ctrl: two requester ports, one response channel
// and the word-wide memory port.
//   slave  : the controller side (accepts requests, drives responses and memory strobes)
//   master : the environment side (requesters, response consumer, memory array)
interface dmem_access_ctrl_if #(
    parameter int unsigned AW = 6
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [1:0]    req0_size;
    logic          req0_unsigned;
    logic [31:0]   req0_addr;
    logic [31:0]   req0_wdata;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [1:0]    req1_size;
    logic          req1_unsigned;
    logic [31:0]   req1_addr;
    logic [31:0]   req1_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_rdata;

    modport master (
        output req0_valid, req0_we, req0_size, req0_unsigned, req0_addr, req0_wdata,
        input  req0_ready,
        output req1_valid, req1_we, req1_size, req1_unsigned, req1_addr, req1_wdata,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_size, req0_unsigned, req0_addr, req0_wdata,
        output req0_ready,
        input  req1_valid, req1_we, req1_size, req1_unsigned, req1_addr, req1_wdata,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer/arbiter. Round-robin shares a big-endian,
// byte-addressed, word-wide memory between the pipeline (port 0) and the
// loader (port 1); byte/half stores use read-modify-write.
// Ports: clk, rst (synchronous, active high), bus (dmem_access_ctrl_if.slave):
//   req0_*/req1_* requests, rsp_* tagged response, mem_* memory port.
// Optional macro DMEM_ERR_EN: misaligned or out-of-range accesses fault
// (rsp_err) instead of being masked/wrapped.
module dmem_access_ctrl #(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned AW          = 6
) (
    input logic               clk,
    input logic               rst,
    dmem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t        state;
    logic          rr_ptr;      // port favoured when both request
    logic          id_q, we_q, uns_q, err_q;
    logic [1:0]    size_q, off_q;
    logic [15:0]   wdata_q;     // only the sub-word lanes are needed after accept

    logic          rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [31:0]   rsp_rdata_q, mem_wdata_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_read_q, mem_write_q;

    logic          gnt, accept, sel_fault;
    logic          sel_we, sel_uns;
    logic [1:0]    sel_size;
    logic [31:0]   sel_addr, sel_wdata;

    // Big-endian lane k sits at bit 24-8k, i.e. shift = (3-k)*8.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {~off, 3'b000});
        h = off[1] ? w[15:0] : w[31:16];
        if (sz == 2'b00)      return uns ? {24'h0, b} : {{24{b[7]}}, b};
        else if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        else                  return w;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic [15:0] wd);
        logic [4:0]  sh;
        logic [31:0] mask, data;
        if (sz == 2'b00) begin
            sh   = {~off, 3'b000};
            mask = 32'h0000_00FF << sh;
            data = {24'h0, wd[7:0]} << sh;
        end else begin
            sh   = off[1] ? 5'd0 : 5'd16;
            mask = 32'h0000_FFFF << sh;
            data = {16'h0, wd} << sh;
        end
        return (w & ~mask) | data;
    endfunction

    // Request selection: lone requester wins, otherwise the round-robin pointer.
    always_comb begin
        gnt       = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
        sel_we    = gnt ? bus.req1_we       : bus.req0_we;
        sel_size  = gnt ? bus.req1_size     : bus.req0_size;
        sel_uns   = gnt ? bus.req1_unsigned : bus.req0_unsigned;
        sel_addr  = gnt ? bus.req1_addr     : bus.req0_addr;
        sel_wdata = gnt ? bus.req1_wdata    : bus.req0_wdata;
    end

    assign accept         = !rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && !gnt;
    assign bus.req1_ready = accept && gnt;

`ifdef DMEM_ERR_EN
    // size 11 is treated as a word
    assign sel_fault   = ((sel_size == 2'b01) && sel_addr[0])
                       || (sel_size[1] && (sel_addr[1:0] != 2'b00))
                       || (sel_addr >= 32'(DEPTH_BYTES));
    assign bus.rsp_err = rsp_err_q;
`else
    // Without fault checking, high address bits wrap and low bits are masked.
    logic unused_err;
    assign unused_err  = ^{sel_addr[31:AW], rsp_err_q};
    assign sel_fault   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Sequencer; memory strobes are set up one state ahead so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rr_ptr      <= ~gnt;
                    id_q        <= gnt;
                    we_q        <= sel_we;
                    uns_q       <= sel_uns;
                    size_q      <= sel_size;
                    off_q       <= sel_addr[1:0];
                    wdata_q     <= sel_wdata[15:0];
                    err_q       <= sel_fault;
                    mem_addr_q  <= {sel_addr[AW-1:2], 2'b00};
                    mem_wdata_q <= sel_wdata;
                    mem_read_q  <= !sel_fault && !(sel_we && sel_size[1]);
                    mem_write_q <= !sel_fault && sel_we && sel_size[1];
                    state       <= ACCESS;
                end
                ACCESS: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    rsp_id_q    <= id_q;
                    rsp_err_q   <= err_q;
                    if (!err_q && we_q && !size_q[1]) begin
                        mem_wdata_q <= merge(bus.mem_rdata, size_q, off_q, wdata_q);
                        mem_write_q <= 1'b1;
                        state       <= MERGE;
                    end else begin
                        rsp_rdata_q <= (err_q || we_q) ? 32'h0
                                     : extract(bus.mem_rdata, size_q, off_q, uns_q);
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                MERGE: begin
                    mem_write_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
endmodule
